// File: rtl/dffrs_init_ctrl.sv
// Preloads a bank of dffrs cells by pulsing their active-low R/S pins from a captured pattern.
// Optional readback check of q_in after the release gap: define DFFRS_INIT_VERIFY_EN.
module dffrs_init_ctrl #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned PULSE_CYCLES = 2,
    parameter int unsigned GAP_CYCLES   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init_req,
    input  logic [WIDTH-1:0] init_value,
    output logic             init_ack,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] R_n,
    output logic [WIDTH-1:0] S_n,
    input  logic [WIDTH-1:0] q_in,
    output logic             mismatch
);

    localparam int unsigned MAX_CYCLES = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        PULSE,
        GAP,
        VERIFY,
        DONE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   cap;

    // Sequencer; R_n/S_n are complementary copies of the captured pattern, so no bit sees both low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            cap      <= '0;
            R_n      <= '1;
            S_n      <= '1;
            init_ack <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            init_ack <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (init_req) begin
                        state    <= PULSE;
                        cnt      <= '0;
                        cap      <= init_value;
                        R_n      <= init_value;
                        S_n      <= ~init_value;
                        init_ack <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                PULSE: begin
                    if (cnt == CNT_W'(PULSE_CYCLES - 1)) begin
                        state <= GAP;
                        cnt   <= '0;
                        R_n   <= '1;
                        S_n   <= '1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        R_n <= cap;
                        S_n <= ~cap;
                    end
                end
                GAP: begin
                    if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
                        cnt <= '0;
`ifdef DFFRS_INIT_VERIFY_EN
                        state <= VERIFY;
`else
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                VERIFY: begin
                    state <= DONE;
                    cnt   <= '0;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end
                DONE: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef DFFRS_INIT_VERIFY_EN
    // Readback flag: cleared on acceptance, sampled once in VERIFY, sticky until then.
    always_ff @(posedge clk) begin
        if (rst) begin
            mismatch <= 1'b0;
        end else if (state == IDLE && init_req) begin
            mismatch <= 1'b0;
        end else if (state == VERIFY) begin
            mismatch <= (q_in != cap);
        end
    end
`else
    logic unused_q_in;
    assign unused_q_in = ^q_in;
    assign mismatch    = 1'b0;
`endif

endmodule

// File: tb/tb_dffrs_init_ctrl.sv
// Self-checking bench for dffrs_init_ctrl: vector table, hand sequences and a done-driven scoreboard.
module tb_dffrs_init_ctrl;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned P     = 2;
    localparam int unsigned G     = 1;
`ifdef DFFRS_INIT_VERIFY_EN
    localparam int unsigned VER   = 1;
`else
    localparam int unsigned VER   = 0;
`endif
    localparam int unsigned SPACING = P + G + 2 + VER;
    localparam int unsigned NSEQ    = 500;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             init_req = 1'b0;
    logic [WIDTH-1:0] init_value = '0;
    logic             init_ack, busy, done, mismatch;
    logic [WIDTH-1:0] R_n, S_n, q_in;

    logic [WIDTH-1:0] model_q = '0;
    logic             force_q = 1'b0;
    logic [WIDTH-1:0] forced_val = '0;
    logic [WIDTH-1:0] sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    assign q_in = force_q ? forced_val : model_q;

    dffrs_init_ctrl #(.WIDTH(WIDTH), .PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
        .clk(clk), .rst(rst), .init_req(init_req), .init_value(init_value),
        .init_ack(init_ack), .busy(busy), .done(done), .R_n(R_n), .S_n(S_n),
        .q_in(q_in), .mismatch(mismatch)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // dffrs cell model, R/S exclusivity and scoreboard pop on every done pulse
    always @(negedge clk) begin
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (!R_n[i])      model_q[i] = 1'b0;
            else if (!S_n[i]) model_q[i] = 1'b1;
        end
        check("mutex", 32'(R_n | S_n), 32'hFF);
        if (done === 1'b1) begin
            if (sb.size() == 0) check("unexpected_done", 32'd1, 32'd0);
            else check("model_q", 32'(model_q), 32'(sb.pop_front()));
        end
    end

    typedef struct {
        logic [WIDTH-1:0] v;
        logic             use_ign;
        logic [WIDTH-1:0] ign;
        logic [WIDTH-1:0] exp_r;
        logic [WIDTH-1:0] exp_s;
    } vec_t;

    vec_t vecs[6];

    // One full request; optionally keeps init_req high with another value while busy.
    task automatic do_init(input vec_t t, input logic exp_mis);
        @(posedge clk); #1;
        init_req   = 1'b1;
        init_value = t.v;
        @(posedge clk); #1;
        check("ack", 32'(init_ack), 32'd1);
        check("busy_rise", 32'(busy), 32'd1);
        check("r_pulse", 32'(R_n), 32'(t.exp_r));
        check("s_pulse", 32'(S_n), 32'(t.exp_s));
        check("mis_clear", 32'(mismatch), 32'd0);
        sb.push_back(t.v);
        init_req   = t.use_ign;
        init_value = t.ign;
        for (int k = 1; k < int'(P); k++) begin
            @(posedge clk); #1;
            check("ack_low", 32'(init_ack), 32'd0);
            check("r_hold", 32'(R_n), 32'(t.exp_r));
            check("s_hold", 32'(S_n), 32'(t.exp_s));
        end
        for (int k = 0; k < int'(G + VER); k++) begin
            @(posedge clk); #1;
            check("gap_r", 32'(R_n), 32'hFF);
            check("gap_s", 32'(S_n), 32'hFF);
            check("gap_busy", 32'(busy), 32'd1);
            check("gap_done", 32'(done), 32'd0);
            check("gap_ack", 32'(init_ack), 32'd0);
        end
        @(posedge clk); #1;
        check("done", 32'(done), 32'd1);
        check("busy_fall", 32'(busy), 32'd0);
        check("done_mis", 32'(mismatch), 32'(exp_mis));
        init_req = 1'b0;
        @(posedge clk); #1;
        check("done_single", 32'(done), 32'd0);
        check("no_ack_after", 32'(init_ack), 32'd0);
        check("mis_sticky", 32'(mismatch), 32'(exp_mis));
    endtask

    initial begin
        vec_t t;
        int cyc, last_done, ndone;
        logic [WIDTH-1:0] cur_v;

        vecs[0] = '{8'hA5, 1'b1, 8'h3C, 8'hA5, 8'h5A};
        vecs[1] = '{8'h00, 1'b0, 8'h00, 8'h00, 8'hFF};
        vecs[2] = '{8'hFF, 1'b1, 8'h00, 8'hFF, 8'h00};
        vecs[3] = '{8'h01, 1'b0, 8'h00, 8'h01, 8'hFE};
        vecs[4] = '{8'h80, 1'b1, 8'h7F, 8'h80, 8'h7F};
        vecs[5] = '{8'h3C, 1'b0, 8'h00, 8'h3C, 8'hC3};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_r", 32'(R_n), 32'hFF);
        check("rst_s", 32'(S_n), 32'hFF);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ack", 32'(init_ack), 32'd0);
        check("rst_mis", 32'(mismatch), 32'd0);
        rst = 1'b0;

        foreach (vecs[i]) do_init(vecs[i], 1'b0);

        // reset during the second pulse cycle: lines release at once, no done
        @(posedge clk); #1;
        init_req   = 1'b1;
        init_value = 8'hA5;
        @(posedge clk); #1;
        check("mid_ack", 32'(init_ack), 32'd1);
        init_req = 1'b0;
        @(posedge clk); #1;
        check("mid_r", 32'(R_n), 32'hA5);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_r", 32'(R_n), 32'hFF);
        check("mid_rst_s", 32'(S_n), 32'hFF);
        check("mid_rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            check("mid_no_done", 32'(done), 32'd0);
        end

`ifdef DFFRS_INIT_VERIFY_EN
        force_q    = 1'b1;
        forced_val = 8'hA4;
        t = '{8'hA5, 1'b0, 8'h00, 8'hA5, 8'h5A};
        do_init(t, 1'b1);
        force_q = 1'b0;
        do_init(t, 1'b0);
`endif

        // back-to-back with init_req held: fixed done spacing, scoreboard checks the pattern
        cur_v      = 8'($urandom);
        init_value = cur_v;
        init_req   = 1'b1;
        last_done  = -1;
        ndone      = 0;
        cyc        = 0;
        while (ndone < int'(NSEQ) && cyc < int'(NSEQ * SPACING + 50)) begin
            @(posedge clk); #1;
            cyc++;
            if (init_ack) begin
                sb.push_back(cur_v);
                cur_v      = 8'($urandom);
                init_value = cur_v;
            end
            if (done) begin
                if (last_done >= 0) check("spacing", 32'(cyc - last_done), 32'(SPACING));
                last_done = cyc;
                ndone++;
            end
        end
        init_req = 1'b0;
        check("b2b_count", 32'(ndone), 32'(NSEQ));
        repeat (SPACING + 2) @(posedge clk);
        #1;
        check("sb_drained", 32'(sb.size()), 32'd1 - 32'(ndone < int'(NSEQ) ? 0 : 1) + 32'(sb.size() > 0 && ndone < int'(NSEQ)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
